sdram_device_model: RTL and testbench
=====================================

# sdram_device_model

Synthesizable single-chip SDR SDRAM responder that sits on the far side of the controller's SDRAM pin interface, in simulation benches and FPGA loopback builds. It decodes CS/RAS/CAS/WE commands, tracks per-bank open rows and the mode register, stores write data in an internal array, and returns read data after the programmed CAS latency. An optional checker flags protocol and timing violations. Bursts are fixed at length 1.

## Interface
- CLK_FREQ, 100: clock frequency (MHz).
- RAW, 12: SDRAM address width.
- DW, 16: data width; must be a multiple of 8.
- CAW, 4: column bits stored (addr[CAW-1:0]).
- RBW, 4: row bits stored (row[RBW-1:0]); array depth = 2^(2+RBW+CAW) words.
- tRCD, 15; tRP, 15; tRFC, 66; tWR, 15: timing limits in ns. Each converts to cycles as ceil(t*CLK_FREQ/1000).
- clk  in  1  clock; one clock domain.
- rst_n  in  1  synchronous, active-low reset.
- sdram_cke  in  1  clock enable; when low, the command is ignored.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command strobes.
- sdram_addr  in  RAW  row, column or mode address; addr[10] = precharge-all.
- sdram_ba  in  2  bank select.
- sdram_dqm  in  DW/8  byte mask, active high.
- sdram_dq  inout  DW  data bus; the model drives it only for read data.
- mode_cl  out  3  current CAS latency.
- err_valid  out  1  one-cycle violation pulse (checker only).
- err_code  out  4  violation code; valid while err_valid is high.

## Operation
- Command decode: cmd = {cs_n, ras_n, cas_n, we_n}, sampled every posedge while cke=1.
  - 0000 LMR; 0001 REFRESH; 0010 PRECHARGE; 0011 ACTIVE; 0100 WRITE; 0101 READ.
  - 0111 NOP, 0110 BURST TERMINATE and cs_n=1 are all no-ops.
- LMR:
  - mode_cl <= addr[6:4] when the value is 2 or 3; other values keep the old CL.
  - Sets mode_valid.
- ACTIVE: bank ba opens row addr.
- PRECHARGE: closes bank ba, or all banks when addr[10]=1.
- WRITE: when bank ba is open, each lane i with dqm[i]=0 stores dq byte i at {ba, row, addr[CAW-1:0]} in the same cycle. A WRITE to a closed bank stores nothing.
- READ to an open bank:
  - Reads the array and enters a CL-deep delay pipeline carrying data and dqm.
  - Lanes with dqm=1 stay Z.
  - A READ to a closed bank returns no data; the bus stays Z.
- Back-to-back READs each return their own word. Pipeline depth is 3.
- Mode register:
  - mode_cl resets to 3; mode_valid resets to 0.
  - Commands issued before the first LMR still execute.
- Reset mid-operation:
  - All banks close.
  - The read pipeline flushes and dq goes Z on the next cycle.
  - All timing counters clear.
  - Array contents are undefined.
- Reset values: mode_cl=3, err_valid=0, err_code=0, sdram_dq=Z.

## Timing
- A READ sampled at edge N drives dq from edge N+CL-1. Data is valid for controller sampling at edge N+CL, and dq returns to Z after one cycle.
- Write data and dqm are sampled on the same edge as the WRITE command.
- Per-bank counters:
  - rcd_cnt loads cRCD-1 on ACTIVE.
  - rp_cnt loads cRP-1 on PRECHARGE.
  - wr_cnt loads cWR-1 on WRITE.
  - All decrement to 0.
- Global counters:
  - rfc_cnt loads cRFC-1 on REFRESH.
  - mrd_cnt loads 2 on LMR.
- A command is legal when the relevant counter reads 0 on its sampling edge.
- err_valid pulses on the edge after the offending command.
- When several violations occur together, the lowest code is reported.
- Violation codes:
  - 1: ACTIVE to an open bank.
  - 2: READ/WRITE to a closed bank.
  - 3: READ/WRITE before tRCD.
  - 4: ACTIVE before tRP.
  - 5: any command other than NOP before tRFC.
  - 6: any command other than NOP before tMRD.
  - 7: REFRESH or LMR with any bank open.
  - 8: PRECHARGE before tWR.
  - 9: READ/WRITE before the first LMR.
  - 10: LMR with unsupported CL or burst length != 1.
- An offending command still updates bank state, except in codes 2 and 10.

## Configuration
- SDRAM_MODEL_CHECK_EN defined: violation counters, priority encoder and err_valid/err_code are built.
- Not defined:
  - Checker logic is removed.
  - err_valid and err_code are tied to 0.
  - Decode, bank tracking, storage and read timing are unchanged.

## Test plan
- LMR addr=0x020 (CL=2), ACTIVE ba=1 row=5, 2 NOPs, WRITE col=3 dq=0xA5C3, then READ col=3 at edge N -> dq=0xA5C3 valid at N+2, then Z; err_valid stays 0.
- Repeat with CL=3 (addr=0x030) -> data valid at N+3. Write 0x1234 with dqm=01, then read -> low byte keeps its old value 0xC3, high byte=0x12.
- READ at N with dqm=10 -> dq[15:8] is Z and dq[7:0] is driven.
- ACTIVE, then READ on the next cycle at 100 MHz (cRCD=2) -> err_valid=1, err_code=3. REFRESH followed by ACTIVE 3 cycles later -> err_code=5.
- Assert rst_n=0 between a READ at N and edge N+2 -> dq is Z at N+2, mode_cl=3 and all banks are closed. A following READ without ACTIVE gives err_code=2 (LMR issued after reset).
- Build without SDRAM_MODEL_CHECK_EN: rerun the tRCD violation -> err_valid stays 0 and the read data path is still correct.

Source files
------------

// File: rtl/sdram_device_model.sv
// SDR SDRAM device model: command decode, bank/row tracking, byte-masked storage, CL-delayed reads.
// Defining SDRAM_MODEL_CHECK_EN builds the protocol/timing checker behind err_valid/err_code.
module sdram_device_model #(
    parameter int CLK_FREQ = 100,
    parameter int RAW      = 12,
    parameter int DW       = 16,
    parameter int CAW      = 4,
    parameter int RBW      = 4,
    parameter int tRCD     = 15,
    parameter int tRP      = 15,
    parameter int tRFC     = 66,
    parameter int tWR      = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sdram_cke,
    input  logic            sdram_cs_n,
    input  logic            sdram_ras_n,
    input  logic            sdram_cas_n,
    input  logic            sdram_we_n,
    input  logic [RAW-1:0]  sdram_addr,
    input  logic [1:0]      sdram_ba,
    input  logic [DW/8-1:0] sdram_dqm,
    inout  wire  [DW-1:0]   sdram_dq,
    output logic [2:0]      mode_cl,
    output logic            err_valid,
    output logic [3:0]      err_code
);

    localparam int NB = DW / 8;
    localparam int AW = 2 + RBW + CAW;

    typedef enum logic [3:0] {
        CMD_LMR = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101
    } cmd_t;

    logic [3:0]     cmd;
    logic           is_lmr, is_ref, is_pre, is_act, is_wr, is_rd, is_nop;
    logic [3:0]     bank_open;
    logic [RBW-1:0] open_row [4];
    logic           mode_valid;
    logic           bank_hit;
    logic [AW-1:0]  mem_addr;
    logic [2:0]     new_cl;
    logic           cl_ok;
    logic [DW-1:0]  mem [2**AW];
    logic [2:0]     pipe_vld;
    logic [DW-1:0]  pipe_data [3];
    logic [NB-1:0]  pipe_dqm [3];
    logic           out_vld;
    logic [DW-1:0]  out_data;
    logic [NB-1:0]  out_dqm;
    logic           unused_addr;

    assign cmd      = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign is_lmr   = sdram_cke && (cmd == CMD_LMR);
    assign is_ref   = sdram_cke && (cmd == CMD_REF);
    assign is_pre   = sdram_cke && (cmd == CMD_PRE);
    assign is_act   = sdram_cke && (cmd == CMD_ACT);
    assign is_wr    = sdram_cke && (cmd == CMD_WR);
    assign is_rd    = sdram_cke && (cmd == CMD_RD);
    assign is_nop   = !(is_lmr || is_ref || is_pre || is_act || is_wr || is_rd);
    assign bank_hit = bank_open[sdram_ba];
    assign mem_addr = {sdram_ba, open_row[sdram_ba], sdram_addr[CAW-1:0]};
    assign new_cl   = sdram_addr[6:4];
    assign cl_ok    = (new_cl == 3'd2) || (new_cl == 3'd3);
    assign unused_addr = ^sdram_addr;

    // Storage has no reset; writes to a closed bank are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && is_wr && bank_hit) begin
            for (int i = 0; i < NB; i++) begin
                if (!sdram_dqm[i]) begin
                    mem[mem_addr][8*i +: 8] <= sdram_dq[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_open  <= '0;
            mode_cl    <= 3'd3;
            mode_valid <= 1'b0;
            pipe_vld   <= '0;
        end else begin
            if (is_lmr) begin
                if (cl_ok) begin
                    mode_cl <= new_cl;
                end
                mode_valid <= 1'b1;
            end
            if (is_act) begin
                bank_open[sdram_ba] <= 1'b1;
                open_row[sdram_ba]  <= sdram_addr[RBW-1:0];
            end
            if (is_pre) begin
                if (sdram_addr[10]) begin
                    bank_open <= '0;
                end else begin
                    bank_open[sdram_ba] <= 1'b0;
                end
            end
            pipe_vld     <= {pipe_vld[1:0], is_rd && bank_hit};
            pipe_data[0] <= mem[mem_addr];
            pipe_data[1] <= pipe_data[0];
            pipe_data[2] <= pipe_data[1];
            pipe_dqm[0]  <= sdram_dqm;
            pipe_dqm[1]  <= pipe_dqm[0];
            pipe_dqm[2]  <= pipe_dqm[1];
        end
    end

    // Stage k holds a read issued k+1 edges ago, so CL picks stage CL-1.
    always_comb begin
        out_vld  = pipe_vld[2];
        out_data = pipe_data[2];
        out_dqm  = pipe_dqm[2];
        if (mode_cl == 3'd2) begin
            out_vld  = pipe_vld[1];
            out_data = pipe_data[1];
            out_dqm  = pipe_dqm[1];
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign sdram_dq[8*i +: 8] = (out_vld && !out_dqm[i]) ? out_data[8*i +: 8] : 8'bz;
    end

`ifdef SDRAM_MODEL_CHECK_EN
    localparam int C_RCD = (tRCD * CLK_FREQ + 999) / 1000;
    localparam int C_RP  = (tRP  * CLK_FREQ + 999) / 1000;
    localparam int C_RFC = (tRFC * CLK_FREQ + 999) / 1000;
    localparam int C_WR  = (tWR  * CLK_FREQ + 999) / 1000;
    localparam logic [7:0] LD_RCD = 8'(C_RCD - 1);
    localparam logic [7:0] LD_RP  = 8'(C_RP - 1);
    localparam logic [7:0] LD_RFC = 8'(C_RFC - 1);
    localparam logic [7:0] LD_WR  = 8'(C_WR - 1);

    logic [7:0]  rcd_cnt [4];
    logic [7:0]  rp_cnt [4];
    logic [7:0]  wr_cnt [4];
    logic [7:0]  rfc_cnt;
    logic [7:0]  mrd_cnt;
    logic [10:1] viol;
    logic [3:0]  code;
    logic        wr_busy;

    // Collect every violation, then keep the lowest-numbered one.
    always_comb begin
        wr_busy = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (wr_cnt[b] != '0 && (sdram_addr[10] || sdram_ba == 2'(b))) begin
                wr_busy = 1'b1;
            end
        end
        viol     = '0;
        viol[1]  = is_act && bank_hit;
        viol[2]  = (is_rd || is_wr) && !bank_hit;
        viol[3]  = (is_rd || is_wr) && rcd_cnt[sdram_ba] != '0;
        viol[4]  = is_act && rp_cnt[sdram_ba] != '0;
        viol[5]  = !is_nop && rfc_cnt != '0;
        viol[6]  = !is_nop && mrd_cnt != '0;
        viol[7]  = (is_ref || is_lmr) && (bank_open != '0);
        viol[8]  = is_pre && wr_busy;
        viol[9]  = (is_rd || is_wr) && !mode_valid;
        viol[10] = is_lmr && (!cl_ok || sdram_addr[2:0] != 3'd0);
        code = 4'd0;
        for (int c = 10; c >= 1; c--) begin
            if (viol[c]) begin
                code = 4'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                rcd_cnt[b] <= '0;
                rp_cnt[b]  <= '0;
                wr_cnt[b]  <= '0;
            end
            rfc_cnt   <= '0;
            mrd_cnt   <= '0;
            err_valid <= 1'b0;
            err_code  <= 4'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (is_act && sdram_ba == 2'(b)) rcd_cnt[b] <= LD_RCD;
                else if (rcd_cnt[b] != '0)       rcd_cnt[b] <= rcd_cnt[b] - 8'd1;
                if (is_pre && (sdram_addr[10] || sdram_ba == 2'(b))) rp_cnt[b] <= LD_RP;
                else if (rp_cnt[b] != '0)                            rp_cnt[b] <= rp_cnt[b] - 8'd1;
                if (is_wr && bank_hit && sdram_ba == 2'(b)) wr_cnt[b] <= LD_WR;
                else if (wr_cnt[b] != '0)                   wr_cnt[b] <= wr_cnt[b] - 8'd1;
            end
            if (is_ref)               rfc_cnt <= LD_RFC;
            else if (rfc_cnt != '0)   rfc_cnt <= rfc_cnt - 8'd1;
            if (is_lmr)               mrd_cnt <= 8'd2;
            else if (mrd_cnt != '0)   mrd_cnt <= mrd_cnt - 8'd1;
            err_valid <= (code != 4'd0);
            err_code  <= code;
        end
    end
`else
    localparam int unused_timing = CLK_FREQ + tRCD + tRP + tRFC + tWR;
    assign err_valid = 1'b0;
    assign err_code  = 4'd0;
`endif

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model; expected error codes follow SDRAM_MODEL_CHECK_EN.
module tb_sdram_device_model;

    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    // The bus is pulled up, so an undriven lane reads as 0xFF.
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;
`ifdef SDRAM_MODEL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [11:0] addr;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    logic [15:0] dq_drv;
    logic        dq_oe;
    tri1  [15:0] sdram_dq;
    logic [2:0]  mode_cl;
    logic        err_valid;
    logic [3:0]  err_code;
    int          checks = 0;
    int          failures = 0;

    assign sdram_dq = dq_oe ? dq_drv : 16'hzzzz;

    always #5 clk = ~clk;

    sdram_device_model dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdram_cke  (cke),
        .sdram_cs_n (cs_n),
        .sdram_ras_n(ras_n),
        .sdram_cas_n(cas_n),
        .sdram_we_n (we_n),
        .sdram_addr (addr),
        .sdram_ba   (ba),
        .sdram_dqm  (dqm),
        .sdram_dq   (sdram_dq),
        .mode_cl    (mode_cl),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drives one command on a falling edge; the DUT samples it on the next rising edge.
    task automatic applyStimulus(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                                 input logic [1:0] m, input logic [15:0] wdata);
        @(negedge clk);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba     = b;
        addr   = a;
        dqm    = m;
        dq_drv = wdata;
        dq_oe  = (c == CMD_WR);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(CMD_NOP, 2'd0, 12'd0, 2'd0, 16'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cke   = 1'b1;
        {cs_n, ras_n, cas_n, we_n} = CMD_NOP;
        ba = 2'd0; addr = 12'd0; dqm = 2'd0; dq_drv = 16'd0; dq_oe = 1'b0;
        idleCycles(3);
        checkOutput("rst_mode_cl", 16'(mode_cl), 16'd3);
        checkOutput("rst_err_valid", 16'(err_valid), 16'd0);
        checkOutput("rst_err_code", 16'(err_code), 16'd0);
        checkOutput("rst_dq_z", sdram_dq, BUS_IDLE);
        rst_n = 1'b1;

        // CL=2 write then read
        applyStimulus(CMD_LMR, 2'd0, 12'h020, 2'b00, 16'd0);
        idleCycles(1);
        checkOutput("lmr_cl2", 16'(mode_cl), 16'd2);
        idleCycles(1);
        applyStimulus(CMD_ACT, 2'd1, 12'd5, 2'b00, 16'd0);
        idleCycles(2);
        applyStimulus(CMD_WR, 2'd1, 12'd3, 2'b00, 16'hA5C3);
        applyStimulus(CMD_RD, 2'd1, 12'd3, 2'b00, 16'd0);
        idleCycles(1);
        checkOutput("cl2_not_yet", sdram_dq, BUS_IDLE);
        checkOutput("cl2_no_err", 16'(err_valid), 16'd0);
        idleCycles(1);
        checkOutput("cl2_data", sdram_dq, 16'hA5C3);
        idleCycles(1);
        checkOutput("cl2_release", sdram_dq, BUS_IDLE);

        // CL=3 with low byte masked on write
        applyStimulus(CMD_PRE, 2'd0, 12'h400, 2'b00, 16'd0);
        applyStimulus(CMD_LMR, 2'd0, 12'h030, 2'b00, 16'd0);
        idleCycles(1);
        checkOutput("lmr_cl3", 16'(mode_cl), 16'd3);
        idleCycles(1);
        applyStimulus(CMD_ACT, 2'd1, 12'd5, 2'b00, 16'd0);
        idleCycles(1);
        applyStimulus(CMD_WR, 2'd1, 12'd3, 2'b01, 16'h1234);
        applyStimulus(CMD_RD, 2'd1, 12'd3, 2'b00, 16'd0);
        idleCycles(1);
        checkOutput("cl3_no_err", 16'(err_valid), 16'd0);
        idleCycles(1);
        checkOutput("cl3_not_yet", sdram_dq, BUS_IDLE);
        idleCycles(1);
        checkOutput("cl3_masked_wr", sdram_dq, 16'h12C3);
        idleCycles(1);
        checkOutput("cl3_release", sdram_dq, BUS_IDLE);

        // Read with the high lane masked
        applyStimulus(CMD_RD, 2'd1, 12'd3, 2'b10, 16'd0);
        idleCycles(3);
        checkOutput("rd_dqm_hi", sdram_dq, 16'hFFC3);
        idleCycles(1);
        checkOutput("rd_dqm_release", sdram_dq, BUS_IDLE);

        // Back-to-back reads return their own words
        applyStimulus(CMD_WR, 2'd1, 12'd4, 2'b00, 16'h5A69);
        applyStimulus(CMD_RD, 2'd1, 12'd3, 2'b00, 16'd0);
        applyStimulus(CMD_RD, 2'd1, 12'd4, 2'b00, 16'd0);
        idleCycles(1);
        checkOutput("b2b_not_yet", sdram_dq, BUS_IDLE);
        idleCycles(1);
        checkOutput("b2b_first", sdram_dq, 16'h12C3);
        idleCycles(1);
        checkOutput("b2b_second", sdram_dq, 16'h5A69);
        idleCycles(1);
        checkOutput("b2b_release", sdram_dq, BUS_IDLE);

        // tRCD violations: write and read one cycle after ACTIVE
        applyStimulus(CMD_ACT, 2'd2, 12'd7, 2'b00, 16'd0);
        applyStimulus(CMD_WR, 2'd2, 12'd1, 2'b00, 16'h3C96);
        applyStimulus(CMD_RD, 2'd2, 12'd1, 2'b00, 16'd0);
        checkOutput("rcd_wr_valid", 16'(err_valid), CHECK_EN ? 16'd1 : 16'd0);
        checkOutput("rcd_wr_code", 16'(err_code), CHECK_EN ? 16'd3 : 16'd0);
        idleCycles(1);
        checkOutput("rcd_pulse_end", 16'(err_valid), 16'd0);
        idleCycles(2);
        checkOutput("rcd_wr_data", sdram_dq, 16'h3C96);
        applyStimulus(CMD_ACT, 2'd3, 12'd2, 2'b00, 16'd0);
        applyStimulus(CMD_RD, 2'd3, 12'd0, 2'b00, 16'd0);
        idleCycles(1);
        checkOutput("rcd_rd_valid", 16'(err_valid), CHECK_EN ? 16'd1 : 16'd0);
        checkOutput("rcd_rd_code", 16'(err_code), CHECK_EN ? 16'd3 : 16'd0);

        // ACTIVE three cycles after REFRESH
        idleCycles(4);
        applyStimulus(CMD_PRE, 2'd0, 12'h400, 2'b00, 16'd0);
        applyStimulus(CMD_REF, 2'd0, 12'd0, 2'b00, 16'd0);
        idleCycles(2);
        applyStimulus(CMD_ACT, 2'd0, 12'd1, 2'b00, 16'd0);
        checkOutput("ref_no_err", 16'(err_valid), 16'd0);
        idleCycles(1);
        checkOutput("rfc_valid", 16'(err_valid), CHECK_EN ? 16'd1 : 16'd0);
        checkOutput("rfc_code", 16'(err_code), CHECK_EN ? 16'd5 : 16'd0);

        // Reset between a CL=2 READ and its data edge
        idleCycles(8);
        applyStimulus(CMD_PRE, 2'd0, 12'h400, 2'b00, 16'd0);
        applyStimulus(CMD_LMR, 2'd0, 12'h020, 2'b00, 16'd0);
        idleCycles(2);
        applyStimulus(CMD_ACT, 2'd0, 12'd1, 2'b00, 16'd0);
        idleCycles(1);
        applyStimulus(CMD_RD, 2'd0, 12'd0, 2'b00, 16'd0);
        idleCycles(1);
        rst_n = 1'b0;
        idleCycles(1);
        checkOutput("rst_flush_dq", sdram_dq, BUS_IDLE);
        checkOutput("rst_mid_cl", 16'(mode_cl), 16'd3);
        rst_n = 1'b1;
        idleCycles(1);
        checkOutput("rst_dq_stays_z", sdram_dq, BUS_IDLE);
        applyStimulus(CMD_LMR, 2'd0, 12'h030, 2'b00, 16'd0);
        idleCycles(2);
        applyStimulus(CMD_RD, 2'd0, 12'd0, 2'b00, 16'd0);
        checkOutput("post_rst_lmr_ok", 16'(err_valid), 16'd0);
        idleCycles(1);
        checkOutput("closed_valid", 16'(err_valid), CHECK_EN ? 16'd1 : 16'd0);
        checkOutput("closed_code", 16'(err_code), CHECK_EN ? 16'd2 : 16'd0);
        idleCycles(2);
        checkOutput("closed_no_data", sdram_dq, BUS_IDLE);
        idleCycles(1);
        checkOutput("closed_no_data2", sdram_dq, BUS_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
